uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line rate in bit/s.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even; 3 behaves as none.
REQ-004 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port tx_data, input, 8 bits: byte to send, sampled only on acceptance.
REQ-008 SHALL have port tx_valid, input, 1 bit: upstream offers tx_data.
REQ-009 SHALL have port tx_ready, output, 1 bit: block can accept a byte this cycle.
REQ-010 SHALL have port txd, output, 1 bit: serial line, idle high, registered.
REQ-011 SHALL have port busy, output, 1 bit: high from the cycle after acceptance to the end of the last stop bit.

Function
REQ-012 SHALL define bit period DIV = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults) clock cycles per bit.
REQ-013 SHALL accept a byte on a posedge where tx_valid && tx_ready, latching tx_data into an internal shift register.
REQ-014 SHALL drive tx_ready = 1 only in state IDLE with rst low, and 0 in all other states.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on acceptance, START->DATA after DIV cycles, DATA->PARITY (or STOP if parity none) after 8 bit periods, PARITY->STOP after DIV cycles, STOP->IDLE after STOP_BITS*DIV cycles.
REQ-016 SHALL drive txd low for exactly DIV cycles starting the cycle after acceptance (1-cycle latency).
REQ-017 SHALL send data LSB first, each bit held for exactly DIV cycles.
REQ-018 SHALL send parity bit = XOR of the 8 data bits (even) or its inverse (odd).
REQ-019 SHALL hold txd high during STOP and IDLE.
REQ-020 SHALL restart the bit-period counter from 0 at acceptance, not free-running, so frames are aligned to acceptance.
REQ-021 SHALL ignore tx_valid and tx_data changes while tx_ready = 0; the frame in flight SHALL be unaffected.
REQ-022 SHALL guarantee at least one IDLE cycle (txd high) between consecutive frames; frame-to-frame minimum spacing is (1+8+P+STOP_BITS)*DIV+1 cycles, where P = 1 if parity is enabled, else 0.

Reset
REQ-023 SHALL, while rst = 1 on a posedge, set state IDLE, counters 0, shift register 0, txd = 1, busy = 0, tx_ready = 0.
REQ-024 SHALL abort a frame when rst asserts mid-frame, with txd high from the next cycle and no partial resumption.
REQ-025 SHALL raise tx_ready on the first posedge with rst = 0.

Structure
REQ-026 SHALL take the FSM state encoding, parity encodings (NONE/ODD/EVEN) and the DIV computation from shared package uart_pkg.
REQ-027 SHALL instantiate one sub-module uart_baud_tick (inputs clk, rst, clear; output tick, pulsing every DIV cycles after clear).

Verification
REQ-028 SHALL cover defaults with tx_data = 0x55: txd = 0, 1,0,1,0,1,0,1,0, 1, each 434 cycles, then busy falls and tx_ready rises.
REQ-029 SHALL cover PARITY = 2 with tx_data = 0x07: parity bit = 1; PARITY = 1 with the same byte: parity bit = 0.
REQ-030 SHALL cover tx_valid held high and tx_data changed from 0xA3 to 0x3C mid-frame: only 0xA3 is sent, then 0x3C is accepted after one IDLE cycle.
REQ-031 SHALL cover rst pulsed for 1 cycle during data bit 3: txd = 1 next cycle, busy = 0, and no further low bits appear.
REQ-032 SHALL cover STOP_BITS = 2 with back-to-back bytes 0xFF and 0x00: stop high for 868 cycles plus 1 idle cycle before the next start bit.
REQ-033 SHALL cover tx_valid = 0 for 2000 cycles after reset: txd stays 1 and busy stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period arithmetic.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Even parity is the plain XOR of the byte; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick pulses for one cycle every DIV cycles, counted from the last clear.
module uart_baud_tick #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional odd/even parity, one or two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int   DIV       = calc_div(CLK_FREQ, BAUD_RATE);
  localparam logic PAR_EN    = (PARITY != PAR_NONE) && (PARITY <= PAR_EVEN);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       tick, tick_clear, accept;

  assign tx_ready   = (state_q == ST_IDLE) && !rst;
  assign accept     = tx_valid && tx_ready;
  assign tick_clear = (state_q == ST_IDLE);
  assign txd        = txd_q;
  assign busy       = busy_q;

  // Holding the timer cleared while idle aligns every frame to its acceptance edge.
  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          shift_d    = tx_data;
          par_d      = parity_bit(tx_data, PARITY);
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            if (PAR_EN) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover default framing, even/odd parity and two stop bits.
module tb_uart_tx;

  localparam int DIV = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rstV, validV, readyV, txdV, busyV;
  logic [7:0] dataV [4];
  int checks = 0;
  int failures = 0;
  logic expQ [$];

  uart_tx dut0 (.clk(clk), .rst(rstV[0]), .tx_data(dataV[0]), .tx_valid(validV[0]),
                .tx_ready(readyV[0]), .txd(txdV[0]), .busy(busyV[0]));
  uart_tx #(.PARITY(2)) dut1 (.clk(clk), .rst(rstV[1]), .tx_data(dataV[1]), .tx_valid(validV[1]),
                .tx_ready(readyV[1]), .txd(txdV[1]), .busy(busyV[1]));
  uart_tx #(.PARITY(1)) dut2 (.clk(clk), .rst(rstV[2]), .tx_data(dataV[2]), .tx_valid(validV[2]),
                .tx_ready(readyV[2]), .txd(txdV[2]), .busy(busyV[2]));
  uart_tx #(.STOP_BITS(2)) dut3 (.clk(clk), .rst(rstV[3]), .tx_data(dataV[3]), .tx_valid(validV[3]),
                .tx_ready(readyV[3]), .txd(txdV[3]), .busy(busyV[3]));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected line levels of one frame: start, data LSB first, optional parity, stop bits.
  task automatic pushFrame(input logic [7:0] data, input int parityMode, input int stopBits);
    expQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(data[i]);
    if (parityMode == 1 || parityMode == 2) expQ.push_back((^data) ^ (parityMode == 1));
    for (int i = 0; i < stopBits; i++) expQ.push_back(1'b1);
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data, input int parityMode,
                               input int stopBits);
    int waitCycles = 0;
    while (readyV[idx] !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    check("readyBeforeSend", readyV[idx], 1);
    validV[idx] = 1'b1;
    dataV[idx] = data;
    pushFrame(data, parityMode, stopBits);
  endtask

  // Entered on the first negedge of the start bit; returns on the idle cycle after the frame.
  task automatic checkOutput(input int idx, input int nBits, input string tag);
    logic level;
    logic expBit;
    int busyLow = 0;
    int readyHigh = 0;
    check({tag, " queueDepth"}, expQ.size() >= nBits, 1);
    for (int b = 0; b < nBits; b++) begin
      expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bz;
      level = txdV[idx];
      for (int k = 0; k < DIV; k++) begin
        if (txdV[idx] !== level) level = 1'bx;
        if (busyV[idx] !== 1'b1) busyLow++;
        if (readyV[idx] !== 1'b0) readyHigh++;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", tag, b), level, expBit);
    end
    check({tag, " busyHeld"}, busyLow, 0);
    check({tag, " readyLowInFrame"}, readyHigh, 0);
    check({tag, " idleTxd"}, txdV[idx], 1);
    check({tag, " idleBusy"}, busyV[idx], 0);
    check({tag, " idleReady"}, readyV[idx], 1);
  endtask

  initial begin
    int txdLow;
    int busyHigh;
    rstV = '1;
    validV = '0;
    for (int i = 0; i < 4; i++) dataV[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("resetTxd%0d", i), txdV[i], 1);
      check($sformatf("resetBusy%0d", i), busyV[i], 0);
      check($sformatf("resetReady%0d", i), readyV[i], 0);
    end
    rstV = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("readyAfterReset%0d", i), readyV[i], 1);

    txdLow = 0;
    busyHigh = 0;
    repeat (2000) begin
      if (txdV[0] !== 1'b1) txdLow++;
      if (busyV[0] !== 1'b0) busyHigh++;
      @(negedge clk);
    end
    check("idle2000Txd", txdLow, 0);
    check("idle2000Busy", busyHigh, 0);

    applyStimulus(0, 8'h55, 0, 1);
    @(negedge clk);
    validV[0] = 1'b0;
    checkOutput(0, 10, "dflt55");

    // Valid stays high while the data changes mid-frame; 0x3C must wait for the idle cycle.
    applyStimulus(0, 8'hA3, 0, 1);
    @(negedge clk);
    dataV[0] = 8'h3C;
    pushFrame(8'h3C, 0, 1);
    checkOutput(0, 10, "heldA3");
    @(negedge clk);
    validV[0] = 1'b0;
    checkOutput(0, 10, "next3C");

    validV[0] = 1'b1;
    dataV[0] = 8'h00;
    @(negedge clk);
    validV[0] = 1'b0;
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    check("abortBit3Low", txdV[0], 0);
    check("abortBit3Busy", busyV[0], 1);
    rstV[0] = 1'b1;
    @(negedge clk);
    check("abortTxd", txdV[0], 1);
    check("abortBusy", busyV[0], 0);
    check("abortReadyInReset", readyV[0], 0);
    rstV[0] = 1'b0;
    @(negedge clk);
    check("abortReadyAfter", readyV[0], 1);
    txdLow = 0;
    busyHigh = 0;
    repeat (11 * DIV) begin
      if (txdV[0] !== 1'b1) txdLow++;
      if (busyV[0] !== 1'b0) busyHigh++;
      @(negedge clk);
    end
    check("abortNoResumeTxd", txdLow, 0);
    check("abortNoResumeBusy", busyHigh, 0);

    applyStimulus(1, 8'h07, 2, 1);
    @(negedge clk);
    validV[1] = 1'b0;
    checkOutput(1, 11, "even07");

    applyStimulus(2, 8'h07, 1, 1);
    @(negedge clk);
    validV[2] = 1'b0;
    checkOutput(2, 11, "odd07");

    applyStimulus(3, 8'hFF, 0, 2);
    @(negedge clk);
    dataV[3] = 8'h00;
    pushFrame(8'h00, 0, 2);
    checkOutput(3, 11, "stop2FF");
    @(negedge clk);
    validV[3] = 1'b0;
    checkOutput(3, 11, "stop200");

    check("queueEmpty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
